// File: rtl/lsu_ctrl.sv
// Load/store sequencer in front of a word-only data memory: sub-word stores use read-modify-write.
// Define LSU_MISALIGN_SPLIT_EN to split word-spanning accesses into two word transactions.
module lsu_ctrl #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int unsigned WordW = DM_ADDRESS - 2;

  typedef enum logic [2:0] {
    StIdle,
    StRd0,
    StWr0,
`ifdef LSU_MISALIGN_SPLIT_EN
    StRd1,
    StWr1,
`endif
    StResp
  } state_e;

  function automatic logic access_err(logic we, logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
  endfunction

  // True when off + size > 4.
  function automatic logic access_span(logic [1:0] f3lo, logic [1:0] off);
    logic s;
    case (f3lo)
      2'b00:   s = 1'b0;
      2'b01:   s = (off == 2'b11);
      default: s = (off != 2'b00);
    endcase
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] size_mask(logic [1:0] f3lo);
    logic [DATA_W-1:0] m;
    case (f3lo)
      2'b00:   m = DATA_W'(32'h0000_00FF);
      2'b01:   m = DATA_W'(32'h0000_FFFF);
      default: m = DATA_W'(32'hFFFF_FFFF);
    endcase
    return m;
  endfunction

  // Merge the store bytes into one word of the two-word window; hi selects the upper word.
  function automatic logic [DATA_W-1:0] merge_word(logic [DATA_W-1:0] rd, logic [DATA_W-1:0] wd,
                                                   logic [1:0] f3lo, logic [1:0] off, logic hi);
    logic [2*DATA_W-1:0] msk;
    logic [2*DATA_W-1:0] wsh;
    logic [2*DATA_W-1:0] m;
    msk = {{DATA_W{1'b0}}, size_mask(f3lo)} << {off, 3'b000};
    wsh = {{DATA_W{1'b0}}, wd} << {off, 3'b000};
    m   = ({rd, rd} & ~msk) | (wsh & msk);
    return hi ? m[2*DATA_W-1:DATA_W] : m[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] load_extract(logic [DATA_W-1:0] lo, logic [DATA_W-1:0] hi,
                                                     logic [2:0] f3, logic [1:0] off);
    logic [2*DATA_W-1:0] dbl;
    logic [DATA_W-1:0]   sh;
    logic [DATA_W-1:0]   r;
    dbl = {hi, lo};
    sh  = DATA_W'(dbl >> {off, 3'b000});
    case (f3[1:0])
      2'b00:   r = {{(DATA_W-8){~f3[2] & sh[7]}}, sh[7:0]};
      2'b01:   r = {{(DATA_W-16){~f3[2] & sh[15]}}, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [1:0]          off_q, off_d;
  logic [WordW-1:0]    w0_q, w0_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                mem_re_q, mem_re_d;
  logic                mem_we_q, mem_we_d;
  logic [DM_ADDRESS-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                req_err;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [DATA_W-1:0]   word0_q, word0_d;
  logic [WordW-1:0]    w1;
  logic                span_q;

  assign w1      = w0_q + WordW'(1);
  assign span_q  = access_span(f3_q[1:0], off_q);
  assign req_err = access_err(req_we, req_funct3);
`else
  assign req_err = access_err(req_we, req_funct3) ||
                   access_span(req_funct3[1:0], req_addr[1:0]);
`endif

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    off_d       = off_q;
    w0_d        = w0_q;
    wdata_d     = wdata_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    word0_d     = word0_q;
`endif
    unique case (state_q)
      StIdle: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          req_ready_d = 1'b0;
          we_d        = req_we;
          f3_d        = req_funct3;
          off_d       = req_addr[1:0];
          w0_d        = req_addr[DM_ADDRESS-1:2];
          wdata_d     = req_wdata;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          if (req_err) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_we && req_funct3[1:0] == 2'b10 && req_addr[1:0] == 2'b00) begin
            state_d     = StWr0;
            mem_we_d    = 1'b1;
            mem_addr_d  = {req_addr[DM_ADDRESS-1:2], 2'b00};
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = StRd0;
            mem_re_d   = 1'b1;
            mem_addr_d = {req_addr[DM_ADDRESS-1:2], 2'b00};
          end
        end
      end
      StRd0: begin
        if (we_q) begin
          state_d     = StWr0;
          mem_we_d    = 1'b1;
          mem_wdata_d = merge_word(mem_rdata, wdata_q, f3_q[1:0], off_q, 1'b0);
`ifdef LSU_MISALIGN_SPLIT_EN
        end else if (span_q) begin
          state_d    = StRd1;
          mem_re_d   = 1'b1;
          mem_addr_d = {w1, 2'b00};
          word0_d    = mem_rdata;
`endif
        end else begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_extract(mem_rdata, {DATA_W{1'b0}}, f3_q, off_q);
        end
      end
      StWr0: begin
`ifdef LSU_MISALIGN_SPLIT_EN
        if (span_q) begin
          state_d    = StRd1;
          mem_re_d   = 1'b1;
          mem_addr_d = {w1, 2'b00};
        end else begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
        end
`else
        state_d     = StResp;
        rsp_valid_d = 1'b1;
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      StRd1: begin
        if (we_q) begin
          state_d     = StWr1;
          mem_we_d    = 1'b1;
          mem_wdata_d = merge_word(mem_rdata, wdata_q, f3_q[1:0], off_q, 1'b1);
        end else begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_extract(word0_q, mem_rdata, f3_q, off_q);
        end
      end
      StWr1: begin
        state_d     = StResp;
        rsp_valid_d = 1'b1;
      end
`endif
      StResp: begin
        rsp_valid_d = 1'b1;
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = StIdle;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      w0_q        <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      word0_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      w0_q        <= w0_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      word0_q     <= word0_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign mem_re     = mem_re_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_funct3 = 3'b010;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed, table-driven bench for lsu_ctrl against a small word-memory model.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_re;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rdata;

  lsu_ctrl #(
    .DM_ADDRESS(9),
    .DATA_W    (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_funct3(mem_funct3),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory model with a side port for preloading.
  logic [31:0] mem [128];
  logic        pre_en;
  logic [6:0]  pre_idx;
  logic [31:0] pre_val;
  int          tot_re = 0;
  int          tot_we = 0;
  int          n_both = 0;
  int          n_misal = 0;
  logic [8:0]  re_log [$];

  assign mem_rdata = mem[mem_addr[8:2]];

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (mem_we) mem[mem_addr[8:2]] <= mem_wdata;
    if (mem_re) begin
      tot_re <= tot_re + 1;
      re_log.push_back(mem_addr);
    end
    if (mem_we) tot_we <= tot_we + 1;
    if (mem_re && mem_we) n_both <= n_both + 1;
    if ((mem_re || mem_we) && mem_addr[1:0] != 2'b00) n_misal <= n_misal + 1;
  end

  int n_cmp;
  int n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    pre_idx = 7'(idx);
    pre_val = v;
    pre_en  = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
    @(negedge clk);
  endtask

  // Issue one request at a negedge, wait for the response and complete the handshake.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                         input logic [31:0] wd, output int lat, output logic err,
                         output logic [31:0] rdata, output int nre, output int nwe,
                         output int log0);
    int re0;
    int we0;
    re0  = tot_re;
    we0  = tot_we;
    log0 = re_log.size();
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    err   = rsp_err;
    rdata = rsp_rdata;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    nre = tot_re - re0;
    nwe = tot_we - we0;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [8:0]  addr;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nre;
    int          nwe;
    int          midx;
    logic [31:0] mval;
  } vec_t;

  function automatic vec_t mkv(logic we, logic [2:0] f3, logic [8:0] addr, logic [31:0] wd,
                               logic err, logic [31:0] rdata, int lat, int nre, int nwe,
                               int midx, logic [31:0] mval);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd; v.err = err; v.rdata = rdata;
    v.lat = lat; v.nre = nre; v.nwe = nwe; v.midx = midx; v.mval = mval;
    return v;
  endfunction

  vec_t        vecs [18];
  int          lat;
  logic        err;
  logic [31:0] rdata;
  int          nre;
  int          nwe;
  int          log0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; pre_en = 1'b0; pre_idx = '0; pre_val = '0;

    vecs[0]  = mkv(1'b0, 3'b000, 9'h003, 32'h0,        1'b0, 32'hFFFFFF88, 2, 1, 0, -1, 32'h0);
    vecs[1]  = mkv(1'b0, 3'b100, 9'h003, 32'h0,        1'b0, 32'h00000088, 2, 1, 0, -1, 32'h0);
    vecs[2]  = mkv(1'b0, 3'b001, 9'h000, 32'h0,        1'b0, 32'hFFFFAABB, 2, 1, 0, -1, 32'h0);
    vecs[3]  = mkv(1'b0, 3'b101, 9'h002, 32'h0,        1'b0, 32'h00008899, 2, 1, 0, -1, 32'h0);
    vecs[4]  = mkv(1'b0, 3'b001, 9'h001, 32'h0,        1'b0, 32'hFFFF99AA, 2, 1, 0, -1, 32'h0);
    vecs[5]  = mkv(1'b0, 3'b010, 9'h000, 32'h0,        1'b0, 32'h8899AABB, 2, 1, 0, -1, 32'h0);
    vecs[6]  = mkv(1'b0, 3'b000, 9'h000, 32'h0,        1'b0, 32'hFFFFFFBB, 2, 1, 0, -1, 32'h0);
    vecs[7]  = mkv(1'b1, 3'b000, 9'h005, 32'h000000EE, 1'b0, 32'h0, 3, 1, 1, 1, 32'h1122EE44);
    vecs[8]  = mkv(1'b1, 3'b001, 9'h00A, 32'hFFFF5678, 1'b0, 32'h0, 3, 1, 1, 2, 32'h5678F00D);
    vecs[9]  = mkv(1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 1'b0, 32'h0, 2, 0, 1, 4, 32'hDEADBEEF);
    vecs[10] = mkv(1'b0, 3'b010, 9'h010, 32'h0,        1'b0, 32'hDEADBEEF, 2, 1, 0, -1, 32'h0);
    vecs[11] = mkv(1'b0, 3'b011, 9'h000, 32'h0,        1'b1, 32'h0, 1, 0, 0, -1, 32'h0);
    vecs[12] = mkv(1'b1, 3'b100, 9'h000, 32'h00000012, 1'b1, 32'h0, 1, 0, 0, 0, 32'h8899AABB);
    vecs[13] = mkv(1'b0, 3'b110, 9'h004, 32'h0,        1'b1, 32'h0, 1, 0, 0, -1, 32'h0);
    vecs[14] = mkv(1'b0, 3'b000, 9'h00B, 32'h0,        1'b0, 32'h00000056, 2, 1, 0, -1, 32'h0);
    vecs[15] = mkv(1'b0, 3'b101, 9'h006, 32'h0,        1'b0, 32'h00001122, 2, 1, 0, -1, 32'h0);
    vecs[16] = mkv(1'b1, 3'b000, 9'h003, 32'h00000077, 1'b0, 32'h0, 3, 1, 1, 0, 32'h7799AABB);
    vecs[17] = mkv(1'b0, 3'b111, 9'h000, 32'h0,        1'b1, 32'h0, 1, 0, 0, -1, 32'h0);

    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 32'h1);
    check("rst_rsp_valid", rsp_valid, 32'h0);
    check("rst_rsp_err", rsp_err, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_mem_re", mem_re, 32'h0);
    check("rst_mem_we", mem_we, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_funct3", mem_funct3, 32'h2);
    rst_n = 1'b1;
    @(negedge clk);

    preload(0, 32'h8899AABB);
    preload(1, 32'h11223344);
    preload(2, 32'hCAFEF00D);
    preload(4, 32'h00000000);

    for (int i = 0; i < 18; i++) begin
      run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, lat, err, rdata, nre, nwe, log0);
      check($sformatf("v%0d_err", i), err, vecs[i].err);
      check($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_nre", i), 32'(nre), 32'(vecs[i].nre));
      check($sformatf("v%0d_nwe", i), 32'(nwe), 32'(vecs[i].nwe));
      if (vecs[i].midx >= 0)
        check($sformatf("v%0d_mem", i), mem[7'(vecs[i].midx)], vecs[i].mval);
    end

    // Word-spanning load across the top of memory.
    preload(0, 32'h11223344);
    preload(127, 32'hAABBCCDD);
    run_req(1'b0, 3'b010, 9'h1FE, 32'h0, lat, err, rdata, nre, nwe, log0);
`ifdef LSU_MISALIGN_SPLIT_EN
    check("wrap_err", err, 32'h0);
    check("wrap_rdata", rdata, 32'h3344AABB);
    check("wrap_lat", 32'(lat), 32'd3);
    check("wrap_nre", 32'(nre), 32'd2);
    check("wrap_nwe", 32'(nwe), 32'd0);
    if (nre >= 2) begin
      check("wrap_addr0", re_log[log0], 32'h1FC);
      check("wrap_addr1", re_log[log0+1], 32'h000);
    end
`else
    check("wrap_err", err, 32'h1);
    check("wrap_rdata", rdata, 32'h0);
    check("wrap_lat", 32'(lat), 32'd1);
    check("wrap_nre", 32'(nre), 32'd0);
    check("wrap_nwe", 32'(nwe), 32'd0);
`endif

    // Word-spanning halfword store.
    run_req(1'b1, 3'b001, 9'h007, 32'h0000BEEF, lat, err, rdata, nre, nwe, log0);
`ifdef LSU_MISALIGN_SPLIT_EN
    check("sst_err", err, 32'h0);
    check("sst_lat", 32'(lat), 32'd5);
    check("sst_nre", 32'(nre), 32'd2);
    check("sst_nwe", 32'(nwe), 32'd2);
    check("sst_mem1", mem[1], 32'hEF22EE44);
    check("sst_mem2", mem[2], 32'h5678F0BE);
`else
    check("sst_err", err, 32'h1);
    check("sst_lat", 32'(lat), 32'd1);
    check("sst_nwe", 32'(nwe), 32'd0);
    check("sst_mem1", mem[1], 32'h1122EE44);
    check("sst_mem2", mem[2], 32'h5678F00D);
`endif

    // Error response held while the consumer stalls, then back-to-back accept.
    req_we = 1'b0; req_funct3 = 3'b011; req_addr = 9'h000; req_wdata = '0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("hold%0d_valid", i), rsp_valid, 32'h1);
      check($sformatf("hold%0d_err", i), rsp_err, 32'h1);
      check($sformatf("hold%0d_rdata", i), rsp_rdata, 32'h0);
      check($sformatf("hold%0d_req_ready", i), req_ready, 32'h0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check("b2b_req_ready", req_ready, 32'h1);
    check("b2b_rsp_valid", rsp_valid, 32'h0);
    @(negedge clk);
    run_req(1'b0, 3'b010, 9'h010, 32'h0, lat, err, rdata, nre, nwe, log0);
    check("b2b_rdata", rdata, 32'hDEADBEEF);
    check("b2b_lat", 32'(lat), 32'd2);

    // Reset asserted while an aligned store is in its write cycle.
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 9'h010; req_wdata = 32'h12345678;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("rst_mid_we_before", mem_we, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_we", mem_we, 32'h0);
    check("rst_mid_re", mem_re, 32'h0);
    check("rst_mid_rsp_valid", rsp_valid, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_req_ready", req_ready, 32'h1);
    check("rst_mid_rsp_valid_after", rsp_valid, 32'h0);
    check("rst_mid_mem", mem[4], 32'hDEADBEEF);
    run_req(1'b0, 3'b010, 9'h010, 32'h0, lat, err, rdata, nre, nwe, log0);
    check("post_rst_rdata", rdata, 32'hDEADBEEF);
    check("post_rst_lat", 32'(lat), 32'd2);

    check("never_re_and_we", 32'(n_both), 32'd0);
    check("mem_addr_aligned", 32'(n_misal), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
